// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared sizing and requester IDs for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int N_REQ          = 3;
  localparam int GRANT_ID_W     = 2;

  typedef enum logic [GRANT_ID_W-1:0] {
    REQ_ALU = 2'd0,
    REQ_LSU = 2'd1,
    REQ_MDU = 2'd2
  } req_id_e;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin one-hot grant: first valid requester at or after the pointer.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);
  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(i_ptr) + i) % N);
      if (!found && i_valid[idx]) begin
        o_grant[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Serialises writeback requesters onto the single RF write port and tracks
// in-flight destination registers in a scoreboard bitmap.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH     = regfile_wb_arbiter_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = regfile_wb_arbiter_pkg::REG_ADDR_WIDTH,
  parameter int N_REQ          = regfile_wb_arbiter_pkg::N_REQ
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [N_REQ-1:0]                i_req_valid,
  output logic [N_REQ-1:0]                o_req_ready,
  input  logic [N_REQ*REG_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]     i_req_data,
  input  logic                            i_issue_en,
  input  logic [REG_ADDR_WIDTH-1:0]       i_issue_addr,
  input  logic [REG_ADDR_WIDTH-1:0]       i_chk_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0]       i_chk_addr_b,
  output logic                            o_busy_a,
  output logic                            o_busy_b,
  output logic                            o_rf_w_en,
  output logic [REG_ADDR_WIDTH-1:0]       o_rf_addr_w,
  output logic [DATA_WIDTH-1:0]           o_rf_din,
  output logic [1:0]                      o_grant_id
);
  import regfile_wb_arbiter_pkg::*;

  localparam int NREG = 2 ** REG_ADDR_WIDTH;

  logic [GRANT_ID_W-1:0]     ptr_q, ptr_d;
  logic [NREG-1:0]           sb_q, sb_d;
  logic                      w_en_q, w_en_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [GRANT_ID_W-1:0]     gid_q, gid_d;

  logic [N_REQ-1:0]          grant;
  logic [GRANT_ID_W-1:0]     gid;
  logic                      xfer;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;

  rr_arbiter #(.N(N_REQ), .PW(GRANT_ID_W)) u_rr (
    .i_valid (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant)
  );

  assign o_req_ready = i_rst ? '0 : grant;
  assign xfer        = |o_req_ready;

  always_comb begin
    gid = '0;
    for (int k = 0; k < N_REQ; k++)
      if (grant[k]) gid = GRANT_ID_W'(k);
  end

  assign sel_addr = i_req_addr[gid*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

  always_comb begin
    ptr_d  = ptr_q;
    w_en_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    gid_d  = gid_q;
    if (xfer) begin
      ptr_d  = (gid == GRANT_ID_W'(N_REQ-1)) ? '0 : gid + 1'b1;
      w_en_d = (sel_addr != '0);
      addr_d = sel_addr;
      data_d = i_req_data[gid*DATA_WIDTH +: DATA_WIDTH];
      gid_d  = gid;
    end
  end

  // Clear on the commit edge first so a same-edge issue to that register wins.
  always_comb begin
    sb_d = sb_q;
    if (w_en_q) sb_d[addr_q] = 1'b0;
    if (i_issue_en && (i_issue_addr != '0)) sb_d[i_issue_addr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q  <= '0;
      sb_q   <= '0;
      w_en_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      gid_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      sb_q   <= sb_d;
      w_en_q <= w_en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gid_q  <= gid_d;
    end
  end

  assign o_busy_a    = sb_q[i_chk_addr_a];
  assign o_busy_b    = sb_q[i_chk_addr_b];
  assign o_rf_w_en   = w_en_q;
  assign o_rf_addr_w = addr_q;
  assign o_rf_din    = data_q;
  assign o_grant_id  = 2'(gid_q);
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL take parameters: DATA_WIDTH, default 32, register data width; REG_ADDR_WIDTH, default 5, register address width; N_REQ, default 3, number of writeback requesters.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk  in  1  single clock; all state on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  N_REQ  requester k has a writeback pending.
- o_req_ready  out  N_REQ  one-hot grant; a transfer occurs when valid[k] && ready[k].
- i_req_addr  in  N_REQ*REG_ADDR_WIDTH  packed destination register; requester k at slice k.
- i_req_data  in  N_REQ*DATA_WIDTH  packed write data; requester k at slice k.
- i_issue_en  in  1  decode issued an instruction that will write a register.
- i_issue_addr  in  REG_ADDR_WIDTH  destination of that issued instruction.
- i_chk_addr_a, i_chk_addr_b  in  REG_ADDR_WIDTH  source operands to check for hazard.
- o_busy_a, o_busy_b  out  1  the checked register has a write in flight.
- o_rf_w_en  out  1  register-file write enable.
- o_rf_addr_w  out  REG_ADDR_WIDTH  register-file write address.
- o_rf_din  out  DATA_WIDTH  register-file write data.
- o_grant_id  out  2  index of the requester whose write is on the o_rf_* outputs.

Function
REQ-003 The block SHALL be the sole driver of the register file's single write port, serialising up to N_REQ requesters.
REQ-004 o_req_ready SHALL be combinational from i_req_valid and the priority pointer, with at most one bit high, and SHALL be 0 for any requester whose valid is low.
REQ-005 Arbitration SHALL be round-robin: search starts at pointer p; after a grant to k, p becomes (k+1) mod N_REQ; with no grant, p holds.
REQ-006 A transfer accepted in cycle n SHALL appear on o_rf_w_en, o_rf_addr_w, o_rf_din and o_grant_id in cycle n+1, and the register file commits it at the edge ending cycle n+1, giving a fixed latency of 1.
REQ-007 With no transfer in cycle n, o_rf_w_en SHALL be 0 in cycle n+1; addr, data and grant_id hold their previous values.
REQ-008 A transfer to register 0 SHALL be accepted (ready asserted) but SHALL produce o_rf_w_en=0 and leave the scoreboard unchanged.
REQ-009 Requesters SHALL hold valid, addr and data stable until their transfer; the block never drops an accepted request, and sustained throughput is one write per cycle.
REQ-010 The scoreboard SHALL be a bitmap over registers 1..2^REG_ADDR_WIDTH-1; i_issue_en with a nonzero i_issue_addr sets that register's bit at the clock edge.
REQ-011 A register's bit SHALL clear at the edge where o_rf_w_en=1 with o_rf_addr_w equal to that register, i.e. the commit edge.
REQ-012 If a set and a clear hit the same register at the same edge, the set SHALL win.
REQ-013 o_busy_a and o_busy_b SHALL be combinational reads of the bitmap; checking address 0 SHALL always give 0.
REQ-014 The scoreboard SHALL NOT count multiple in-flight writes to one register: a single clear releases it, and decode must not issue a second writer while the register is busy.

Reset
REQ-015 While i_rst=1 at a clock edge:
- pointer p SHALL be set to 0;
- the scoreboard SHALL be cleared;
- o_rf_w_en, o_rf_addr_w, o_rf_din and o_grant_id SHALL be set to 0;
- o_req_ready SHALL be forced to 0.
REQ-016 Reset asserted mid-operation SHALL discard any registered write not yet committed (o_rf_w_en=0 in the cycle after the reset edge).

Structure
REQ-017 A shared package SHALL hold DATA_WIDTH, REG_ADDR_WIDTH, N_REQ and the requester IDs: REQ_ALU=0, REQ_LSU=1, REQ_MDU=2.
REQ-018 The round-robin grant logic SHALL be a sub-module, rr_arbiter (inputs valid, pointer; output one-hot grant), instantiated once.

Verification
REQ-019 Reset, then all three requesters valid continuously (addrs 1, 2, 3) -> grants follow 0,1,2,0,...; o_rf_w_en=1 every cycle from the second cycle on.
REQ-020 Issue r5, then LSU writes r5=0xDEADBEEF -> o_busy_a (chk=5) stays 1 through the o_rf_w_en cycle and is 0 in the cycle after.
REQ-021 ALU write to r0 with data 0x1234 -> ready=1, o_rf_w_en=0 next cycle, scoreboard unchanged.
REQ-022 Issue r7 at the same edge as the commit of an earlier r7 write -> r7 remains busy.
REQ-023 i_rst pulsed in the cycle a transfer is accepted -> o_rf_w_en=0 next cycle, all busy=0, next grant goes to requester 0.
REQ-024 Only MDU valid, after a grant to ALU (p=1) -> MDU granted immediately, and p becomes 0.
